// File: rtl/audio_dac_out_if.sv
// Write-side handshake for audio_dac_out: one stereo frame per accepted write.
interface audio_dac_out_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata_left;
    logic [DATA_WIDTH-1:0] writedata_right;
    logic                  write_ready;

    modport master (
        output write,
        output writedata_left,
        output writedata_right,
        input  write_ready
    );

    modport slave (
        input  write,
        input  writedata_left,
        input  writedata_right,
        output write_ready
    );
endinterface

// File: rtl/audio_dac_out.sv
// audio_dac_out: frame FIFO + I2S serializer slaved to CODEC BCLK/LRCK; define AUDIO_DAC_HOLD_EN to repeat the last frame on underflow.
// Latency: AUD_DACDAT follows a BCLK pin falling edge by 3 CLOCK_50 cycles; fifo_level/write_ready update the cycle after push/pop.
// Backpressure: write_ready drops while FIFO_DEPTH frames are stored; a write while not ready is dropped.
module audio_dac_out #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        reset_n,
    audio_dac_out_if.slave              wr,
    input  logic                        AUD_BCLK,
    input  logic                        AUD_DACLRCK,
    output logic                        AUD_DACDAT,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] right;
    } frame_t;

    frame_t                mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q, count_d;
    logic                  bclk_s1_q, bclk_s2_q, bclk_d_q;
    logic                  lrck_s1_q, lrck_s2_q;
    logic                  lrck_prev_q, lrck_prev_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  dat_q, dat_d;
    logic                  uf_q, uf_d;
    logic                  bclk_fall, left_start, right_start;
    logic                  fifo_empty, push, pop;
    frame_t                head, empty_frame;
`ifdef AUDIO_DAC_HOLD_EN
    frame_t                last_q;
`endif

    assign wr.write_ready = (count_q != (AW+1)'(FIFO_DEPTH));
    assign AUD_DACDAT     = dat_q;
    assign underflow      = uf_q;
    assign fifo_level     = count_q;

    always_comb begin
        fifo_empty  = (count_q == '0);
        push        = wr.write && wr.write_ready;
        bclk_fall   = bclk_d_q && !bclk_s2_q;
        left_start  = bclk_fall && lrck_prev_q && !lrck_s2_q;
        right_start = bclk_fall && !lrck_prev_q && lrck_s2_q;
        // An empty FIFO at the left start underflows even if a push lands in the same cycle.
        pop         = left_start && !fifo_empty;
        head        = mem_q[rd_ptr_q];
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
`ifdef AUDIO_DAC_HOLD_EN
        empty_frame = last_q;
`else
        empty_frame = '0;
`endif
    end

    always_comb begin
        shift_d     = shift_q;
        hold_d      = hold_q;
        dat_d       = dat_q;
        uf_d        = 1'b0;
        lrck_prev_d = lrck_prev_q;
        if (bclk_fall) begin
            lrck_prev_d = lrck_s2_q;
            if (left_start) begin
                if (!fifo_empty) begin
                    shift_d = head.left;
                    hold_d  = head.right;
                end else begin
                    shift_d = empty_frame.left;
                    hold_d  = empty_frame.right;
                    uf_d    = 1'b1;
                end
            end else if (right_start) begin
                shift_d = hold_q;
            end else begin
                // Slot-start edges skip this update, producing the I2S one-bit delay.
                dat_d   = shift_q[DATA_WIDTH-1];
                shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_s1_q   <= 1'b0;
            bclk_s2_q   <= 1'b0;
            bclk_d_q    <= 1'b0;
            lrck_s1_q   <= 1'b0;
            lrck_s2_q   <= 1'b0;
            lrck_prev_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            dat_q       <= 1'b0;
            uf_q        <= 1'b0;
`ifdef AUDIO_DAC_HOLD_EN
            last_q      <= '0;
`endif
        end else begin
            bclk_s1_q   <= AUD_BCLK;
            bclk_s2_q   <= bclk_s1_q;
            bclk_d_q    <= bclk_s2_q;
            lrck_s1_q   <= AUD_DACLRCK;
            lrck_s2_q   <= lrck_s1_q;
            lrck_prev_q <= lrck_prev_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            dat_q       <= dat_d;
            uf_q        <= uf_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
`ifdef AUDIO_DAC_HOLD_EN
            if (pop)  last_q <= head;
`endif
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q] <= {wr.writedata_left, wr.writedata_right};
    end
endmodule

// File: tb/tb_audio_dac_out.sv
// Self-checking bench for audio_dac_out: BCLK/LRCK model (64 BCLK per frame) with a frame scoreboard.
module tb_audio_dac_out;
    localparam int DW = 24;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       aud_bclk = 1'b1;
    logic       aud_lrck = 1'b0;
    logic       aud_dacdat;
    logic       underflow;
    logic [2:0] fifo_level;

    audio_dac_out_if #(.DATA_WIDTH(DW)) wr_if ();

    audio_dac_out #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .CLOCK_50    (clk),
        .reset_n     (reset_n),
        .wr          (wr_if),
        .AUD_BCLK    (aud_bclk),
        .AUD_DACLRCK (aud_lrck),
        .AUD_DACDAT  (aud_dacdat),
        .underflow   (underflow),
        .fifo_level  (fifo_level)
    );

    always #10 clk = ~clk;

    int          n_checks  = 0;
    int          n_err     = 0;
    int          pos       = 0;
    int          cur_pos   = 0;
    int          rst_epoch = 0;
    int          uf_total  = 0;
    bit          bclk_en   = 1'b0;
    logic [47:0] exp_q[$];
    event        lstart_ev;

    logic [23:0] sl [8] = '{24'h000001, 24'h800000, 24'hC3C3C3, 24'h3C3C3C,
                           24'hFFFFFF, 24'h7FFFFF, 24'h0F00F0, 24'hE01234};
    logic [23:0] sr [8] = '{24'hFFFFFE, 24'h000080, 24'h123456, 24'hABCDEF,
                           24'h000000, 24'h800001, 24'h5A5A5A, 24'h09876F};

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One write cycle starting at a falling clk edge; accepted frames go to the scoreboard.
    task automatic push(input logic [23:0] l, input logic [23:0] r, input bit acc);
        wr_if.write           = 1'b1;
        wr_if.writedata_left  = l;
        wr_if.writedata_right = r;
        if (acc) exp_q.push_back({l, r});
        @(negedge clk);
        wr_if.write = 1'b0;
    endtask

    // CODEC clock model: 4 clk low, 4 clk high per bit; LRCK toggles on the falls of bits 0 and 32.
    initial begin : bclk_gen
        forever begin
            @(negedge clk);
            if (bclk_en) begin
                if (pos == 0)       aud_lrck = 1'b0;
                else if (pos == 32) aud_lrck = 1'b1;
                aud_bclk = 1'b0;
                cur_pos  = pos;
                if (pos == 0) -> lstart_ev;
                repeat (4) @(negedge clk);
                aud_bclk = 1'b1;
                repeat (3) @(negedge clk);
                pos = (pos + 1) % 64;
            end
        end
    end

    initial begin : uf_counter
        forever begin
            @(negedge clk);
            if (underflow === 1'b1) uf_total++;
        end
    end

    // Samples AUD_DACDAT on BCLK rises and checks each complete frame against the scoreboard.
    initial begin : monitor
        int          p, k, mon_epoch, uf_base;
        bit          armed, frame_valid, tail_ok;
        logic        exp_uf, d;
        logic [23:0] mon_l, mon_r, exp_l, exp_r, last_l, last_r;
        logic [47:0] f;
        mon_epoch = 0; uf_base = 0; armed = 0; frame_valid = 0; tail_ok = 1;
        exp_uf = 0; mon_l = '0; mon_r = '0; exp_l = '0; exp_r = '0; last_l = '0; last_r = '0;
        forever begin
            @(posedge aud_bclk);
            p = cur_pos;
            k = p % 32;
            if (rst_epoch != mon_epoch) begin
                mon_epoch = rst_epoch; armed = 0; frame_valid = 0; last_l = '0; last_r = '0;
            end
            if (p == 0 && armed) begin
                frame_valid = 1;
                tail_ok     = 1;
                if (exp_q.size() > 0) begin
                    f = exp_q.pop_front();
                    exp_l = f[47:24]; exp_r = f[23:0];
                    last_l = exp_l;   last_r = exp_r;
                    exp_uf = 1'b0;
                end else begin
                    exp_uf = 1'b1;
`ifdef AUDIO_DAC_HOLD_EN
                    exp_l = last_l; exp_r = last_r;
`else
                    exp_l = '0; exp_r = '0;
`endif
                end
            end
            if (p >= 32) armed = 1;
            d = aud_dacdat;
            if (k >= 1 && k <= DW) begin
                if (p < 32) mon_l = {mon_l[22:0], d};
                else        mon_r = {mon_r[22:0], d};
            end else if (d !== 1'b0) begin
                tail_ok = 0;
            end
            if (p == 63) begin
                if (frame_valid) begin
                    chk("frame_left",  {24'h0, mon_l}, {24'h0, exp_l});
                    chk("frame_right", {24'h0, mon_r}, {24'h0, exp_r});
                    chk("frame_tail_zero", {47'h0, tail_ok}, 48'h1);
                    chk("frame_uf_pulses", 48'(uf_total - uf_base), {47'h0, exp_uf});
                end
                uf_base = uf_total;
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(negedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        wr_if.write = 1'b0; wr_if.writedata_left = '0; wr_if.writedata_right = '0;
        #1;
        chk("rst_level_async", {45'h0, fifo_level}, 48'h0);
        chk("rst_ready_async", {47'h0, wr_if.write_ready}, 48'h1);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_dacdat", {47'h0, aud_dacdat}, 48'h0);
        chk("rst_underflow", {47'h0, underflow}, 48'h0);
        chk("rst_level", {45'h0, fifo_level}, 48'h0);

        // Single frame: no pop until a real LRCK 1->0 edge.
        push(24'hA5A5A5, 24'h5A5A5A, 1);
        chk("t1_level_push", {45'h0, fifo_level}, 48'h1);
        bclk_en = 1'b1;
        @(lstart_ev); repeat (6) @(negedge clk);
        chk("t1_level_noedge", {45'h0, fifo_level}, 48'h1);
        @(lstart_ev); repeat (6) @(negedge clk);
        chk("t1_level_pop", {45'h0, fifo_level}, 48'h0);

        // Fill with BCLK stopped; the fifth write must be dropped.
        bclk_en = 1'b0;
        repeat (20) @(negedge clk);
        push(24'h11AA22, 24'h33BB44, 1);
        push(24'h55CC66, 24'h77DD88, 1);
        push(24'h99EEAA, 24'hBBFFCC, 1);
        push(24'hDD0011, 24'hFF2233, 1);
        chk("t2_level_full", {45'h0, fifo_level}, 48'h4);
        chk("t2_ready_full", {47'h0, wr_if.write_ready}, 48'h0);
        push(24'hDEADBE, 24'hEFCAFE, 0);
        chk("t2_level_drop", {45'h0, fifo_level}, 48'h4);
        bclk_en = 1'b1;
        repeat (4) @(lstart_ev);
        repeat (10) @(negedge clk);
        push(24'h123456, 24'h654321, 1);
        repeat (2) @(lstart_ev);

        // Underflow frame just started; queue two, then push on the exact pop cycle.
        repeat (10) @(negedge clk);
        push(sl[0], sr[0], 1);
        push(sl[1], sr[1], 1);
        @(lstart_ev); repeat (2) @(negedge clk);
        chk("t4_level_before", {45'h0, fifo_level}, 48'h2);
        push(sl[2], sr[2], 1);
        chk("t4_level_simul", {45'h0, fifo_level}, 48'h2);
        for (int i = 3; i < 8; i++) begin
            @(lstart_ev); repeat (10) @(negedge clk);
            push(sl[i], sr[i], 1);
        end
        repeat (3) @(lstart_ev);

        // Reset in the middle of a left slot carrying all ones.
        repeat (10) @(negedge clk);
        push(24'hFFFFFF, 24'hFFFFFF, 1);
        push(24'hFFFFFF, 24'hFFFFFF, 1);
        @(lstart_ev); repeat (80) @(negedge clk);
        chk("t5_level_pre", {45'h0, fifo_level}, 48'h1);
        chk("t5_dacdat_pre", {47'h0, aud_dacdat}, 48'h1);
        #2;
        reset_n = 1'b0;
        rst_epoch++;
        exp_q.delete();
        #1;
        chk("t5_dacdat_rst", {47'h0, aud_dacdat}, 48'h0);
        chk("t5_level_rst", {45'h0, fifo_level}, 48'h0);
        chk("t5_ready_rst", {47'h0, wr_if.write_ready}, 48'h1);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        push(24'h800001, 24'h7FFFFE, 1);
        repeat (2) @(lstart_ev);
        repeat (10) @(negedge clk);
        chk("drain_queue", 48'(exp_q.size()), 48'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
